// File: rtl/ysyx_22041207_ifu.sv
// ysyx_22041207_ifu
//
// Instruction fetch unit. It generates the fetch PC and issues one request at a
// time to the instruction memory. It hands one (inst, pc) pair per fetched
// instruction to the IF/ID pipeline register. A decode stall freezes the
// outputs. A branch/jump redirect from execute squashes any in-flight fetch and
// restarts fetching at the new address.
//
// Ports
//   clk, rst          : clock, synchronous active-high reset
//   stall             : downstream cannot accept, hold inst/pc/inst_valid
//   redirect          : restart fetch at redirect_pc (beats stall)
//   redirect_pc       : new 64-bit fetch address
//   imem_req_valid    : request valid (asserted only in REQ)
//   imem_req_ready    : memory accepts the request this cycle
//   imem_req_addr     : request address (always the current fetch_pc)
//   imem_resp_valid   : response valid, only looked at while in WAIT
//   imem_resp_data    : 32-bit instruction word
//   inst, pc          : instruction and its PC towards IF/ID
//   inst_valid        : inst/pc hold a live instruction

module ysyx_22041207_ifu #(
    parameter logic [63:0] RESET_PC = 64'h8000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect,
    input  logic [63:0] redirect_pc,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [63:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    output logic [31:0] inst,
    output logic [63:0] pc,
    output logic        inst_valid
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        HOLD
    } state_t;

    state_t      state, state_n;
    logic [63:0] fetch_pc, fetch_pc_n;
    logic        drop, drop_n;
    logic [31:0] hold_inst;
    logic [63:0] hold_pc;

    logic        capture;
    logic        deliver;
    logic [31:0] deliver_inst;
    logic [63:0] deliver_pc;

    // The request is simply the current fetch PC while REQ is active, so the
    // address stays stable under backpressure until a redirect changes fetch_pc.
    assign imem_req_valid = (state == REQ);
    assign imem_req_addr  = fetch_pc;

    // Next-state logic. A redirect overrides everything except reset. Any
    // request the memory has already accepted is remembered through 'drop', so
    // the one response still owed to us is swallowed and never delivered.
    always_comb begin
        state_n      = state;
        fetch_pc_n   = fetch_pc;
        drop_n       = drop;
        capture      = 1'b0;
        deliver      = 1'b0;
        deliver_inst = hold_inst;
        deliver_pc   = hold_pc;

        if (redirect) begin
            fetch_pc_n = redirect_pc;
            case (state)
                IDLE: begin
                    state_n = REQ;
                    drop_n  = 1'b0;
                end
                REQ: begin
                    // A handshake in the redirect cycle still leaves a response
                    // owed to us, and that response belongs to the old path.
                    if (imem_req_ready) begin
                        state_n = WAIT;
                        drop_n  = 1'b1;
                    end
                end
                WAIT: begin
                    if (imem_resp_valid) begin
                        state_n = REQ;
                        drop_n  = 1'b0;
                    end else begin
                        drop_n  = 1'b1;
                    end
                end
                HOLD: begin
                    state_n = REQ;
                end
                default: begin
                    state_n = IDLE;
                end
            endcase
        end else begin
            case (state)
                IDLE: begin
                    state_n = REQ;
                end
                REQ: begin
                    if (imem_req_ready) begin
                        state_n = WAIT;
                    end
                end
                WAIT: begin
                    if (imem_resp_valid) begin
                        if (drop) begin
                            // fetch_pc already holds the redirect target
                            drop_n  = 1'b0;
                            state_n = REQ;
                        end else begin
                            fetch_pc_n = fetch_pc + 64'd4;
                            if (stall) begin
                                capture = 1'b1;
                                state_n = HOLD;
                            end else begin
                                deliver      = 1'b1;
                                deliver_inst = imem_resp_data;
                                deliver_pc   = fetch_pc;
                                state_n      = REQ;
                            end
                        end
                    end
                end
                HOLD: begin
                    if (!stall) begin
                        deliver = 1'b1;
                        state_n = REQ;
                    end
                end
                default: begin
                    state_n = IDLE;
                end
            endcase
        end
    end

    // FSM state, fetch PC and drop flag
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            fetch_pc <= RESET_PC;
            drop     <= 1'b0;
        end else begin
            state    <= state_n;
            fetch_pc <= fetch_pc_n;
            drop     <= drop_n;
        end
    end

    // Hold buffer. It parks a response that arrived while decode was stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_inst <= 32'd0;
            hold_pc   <= 64'd0;
        end else if (capture) begin
            hold_inst <= imem_resp_data;
            hold_pc   <= fetch_pc;
        end
    end

    // Output register towards IF/ID. Under stall everything is frozen. Without
    // stall, inst_valid drops to zero in any cycle with nothing new to deliver.
    always_ff @(posedge clk) begin
        if (rst) begin
            inst       <= 32'd0;
            pc         <= 64'd0;
            inst_valid <= 1'b0;
        end else if (redirect) begin
            inst_valid <= 1'b0;
        end else if (!stall) begin
            if (deliver) begin
                inst       <= deliver_inst;
                pc         <= deliver_pc;
                inst_valid <= 1'b1;
            end else begin
                inst_valid <= 1'b0;
            end
        end
    end

endmodule

// File: doc/ysyx_22041207_ifu.md
# ysyx_22041207_ifu

Instruction fetch unit that generates the fetch PC, issues single-outstanding requests to the instruction memory port, and delivers one `(inst, pc)` pair per fetched instruction to the IF/ID pipeline register. It sits directly upstream of the IF/ID register. It honours two controls: a hazard stall from decode (the same signal that bubbles IF/ID) and a branch/jump redirect from execute.

## Interface
- `RESET_PC`, default 64'h8000_0000: first fetch address after reset.
- `clk` in 1: clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `stall` in 1: downstream cannot accept; hold outputs.
- `redirect` in 1: squash in-flight fetch and restart at `redirect_pc`.
- `redirect_pc` in 64: new fetch address, valid when `redirect`=1.
- `imem_req_valid` out 1: fetch request valid.
- `imem_req_ready` in 1: memory accepts the request this cycle.
- `imem_req_addr` out 64: fetch address.
- `imem_resp_valid` in 1: response data valid.
- `imem_resp_data` in 32: fetched instruction word.
- `inst` out 32: instruction to IF/ID.
- `pc` out 64: PC of `inst`.
- `inst_valid` out 1: `inst`/`pc` hold a live instruction.

## Operation
- Internal state: `fetch_pc` (64), FSM state, hold buffer (`hold_inst` 32, `hold_pc` 64), `drop` flag.
- FSM states: IDLE, REQ, WAIT, HOLD.
  - IDLE: entered on reset, lasts one cycle, then goes to REQ.
  - REQ: `imem_req_valid`=1 and `imem_req_addr`=`fetch_pc`. On `imem_req_ready`=1, go to WAIT.
  - WAIT: await `imem_resp_valid`. On response with `drop`=0:
    - if `stall`=0, load outputs (`inst_valid`=1), set `fetch_pc`+=4, go to REQ;
    - if `stall`=1, capture into the hold buffer, set `fetch_pc`+=4, go to HOLD.
  - WAIT, response with `drop`=1: discard the data, clear `drop`, go to REQ (`fetch_pc` was already set by the redirect).
  - HOLD: when `stall`=0, move the hold buffer to the outputs with `inst_valid`=1, go to REQ.
- Output register update rule:
  - `stall`=1: `inst`, `pc` and `inst_valid` keep their values.
  - `stall`=0 with no delivery this cycle: `inst_valid`<=0; `inst` and `pc` keep their values.
- Redirect (priority rst > redirect > stall > normal):
  - `fetch_pc`<=`redirect_pc`; `inst_valid`<=0 regardless of `stall`.
  - REQ: no request was accepted, so the new address is presented next cycle. A handshake in the same cycle as `redirect` counts as accepted: go to WAIT with `drop`=1.
  - WAIT: set `drop`=1 and stay in WAIT unless the response arrives in the same cycle. In that case discard it and go to REQ.
  - HOLD: discard the hold buffer and go to REQ.
  - IDLE: go to REQ with `redirect_pc`.
- Only one request is ever outstanding. `imem_resp_valid` outside WAIT is ignored.
- PC arithmetic: 64-bit, wraps modulo 2^64 with no fault. Alignment is not checked.

## Timing
- Reset values: `inst`=0, `pc`=0, `inst_valid`=0, `imem_req_valid`=0, `imem_req_addr`=`RESET_PC`, `fetch_pc`=`RESET_PC`, `drop`=0, state IDLE.
- Reset mid-operation discards any outstanding request. A later stale response lands in IDLE/REQ and is ignored.
- Cycle 0 is the first edge with `rst`=0, and the FSM is in IDLE. From cycle 1, `imem_req_valid`=1.
- If the request is accepted at edge N and `imem_resp_valid` is asserted during cycle N+1, `inst_valid`=1 in cycle N+2.
- Best-case throughput is one instruction per 2 cycles with a 1-cycle memory.
- `imem_req_addr` is stable while `imem_req_valid`=1 and `imem_req_ready`=0, unless `redirect` arrives.
- `redirect` takes effect at the next edge: `inst_valid`=0 and the new address is on `imem_req_addr` the following cycle when in REQ/IDLE/HOLD.

## Test plan
- Reset release, with `imem_req_ready`=1 and a 1-cycle memory returning 32'h00000013:
  - requests go to 0x80000000, 0x80000004, …;
  - `inst_valid` pulses every 2nd cycle with `pc` 0x80000000, 0x80000004.
- `stall` held for 5 cycles while a response arrives:
  - outputs unchanged during the stall;
  - the held instruction appears with `inst_valid`=1 on the first unstalled cycle;
  - no instruction is lost or duplicated.
- `redirect`=1 with `redirect_pc`=0x80001000 while in WAIT:
  - the in-flight response (0x80000008) is dropped;
  - the next `imem_req_addr` is 0x80001000;
  - the next delivered `pc` is 0x80001000.
- `redirect` and `imem_resp_valid` in the same cycle:
  - the response is discarded and `inst_valid`=0;
  - the next fetch is at `redirect_pc`.
- `imem_req_ready` held low for 3 cycles: `imem_req_addr` is stable at 0x80000000 and exactly one handshake occurs.
- `rst` asserted while in WAIT, then a stale `imem_resp_valid`: the response is ignored and the first delivered `pc` is 0x80000000.
